mem_stage_ctrl: RTL
===================

Name: mem_stage_ctrl

Overview:
- Memory-stage controller; consumes the execute stage's MemRead/MemWr, address (ALU_Out) and store data (rd2).
- Acts as the initiator toward the data-memory responder on a req/ready bus. Aligns store data and generates byte enables; sign- or zero-extends load data.
- Stalls the pipeline while a transaction is outstanding and flags misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles in BUSY waiting for bus_ready before aborting (must be ≥1)

Ports:
clk  input  1  clock; all state updates on rising edge
n_rst  input  1  synchronous, active-high reset
MemRead  input  1  load request from execute stage
MemWr  input  1  store request from execute stage
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALU_Out  input  32  byte address
rd2  input  32  store data, right-justified
bus_req  output  1  transaction request to data memory
bus_we  output  1  1 = write
bus_addr  output  32  word-aligned address, ALU_Out with [1:0]=0
bus_wdata  output  32  store data shifted to byte lane
bus_be  output  4  byte enables
bus_ready  input  1  responder completion, sampled only while bus_req=1
bus_rdata  input  32  read word, valid with bus_ready
mem_stall  output  1  hold upstream stages
load_data  output  32  extended load result
load_valid  output  1  one-cycle pulse, load_data valid
access_fault  output  1  one-cycle pulse on misaligned, illegal or timeout

Behaviour:
- Interface: one clock, clk. Reset n_rst is synchronous and active-high.
- Reset:
  - State goes to IDLE; timeout counter cleared.
  - All outputs 0: bus_req, bus_we, bus_addr, bus_wdata, bus_be, mem_stall, load_data, load_valid, access_fault.
  - Reset mid-transaction: bus_req drops at the next edge; the transaction is abandoned and no load_valid is produced.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Request = MemRead|MemWr. Both asserted is treated as a store (write priority).
  - Legality:
    - Stores accept funct3 000/001/010 only.
    - Loads accept 000/001/010/100/101.
    - Anything else is illegal.
  - Misalignment: H/HU with addr[0]=1, or W with addr[1:0]≠00.
  - Legal and aligned:
    - Register bus_addr, bus_we, bus_be and bus_wdata; also capture funct3 and addr[1:0].
    - Go to BUSY.
    - mem_stall=1 combinationally in this cycle.
  - Illegal or misaligned:
    - No bus transaction, no stall, stay IDLE.
    - access_fault=1 for exactly the next cycle.
- Byte enables and store data:
  - B: be = 0001 << addr[1:0]; wdata = {4{rd2[7:0]}}.
  - H: be = 0011 << addr[1:0]; wdata = {2{rd2[15:0]}}.
  - W: be = 1111; wdata = rd2.
  - Loads use the same be.
- BUSY:
  - bus_req=1 and mem_stall=1.
  - Counter increments each cycle.
  - bus_ready=1:
    - Drop bus_req at the next edge and go to DONE.
    - For loads, register the extended data.
  - Counter reaches TIMEOUT_CYCLES without bus_ready:
    - Drop bus_req and go to DONE.
    - access_fault=1 and load_data=0 in DONE.
  - MemRead, MemWr, ALU_Out and rd2 are ignored outside IDLE.
- Load extension:
  - Select the byte/half of bus_rdata by the captured addr[1:0].
  - 000/001: sign-extend. 100/101: zero-extend. 010: full word.
- DONE (exactly 1 cycle):
  - mem_stall=0.
  - load_valid=1 for a successful load only. Stores and timeouts give load_valid=0.
  - load_data holds its value until the next load completes.
  - Always returns to IDLE. A new request is accepted from the IDLE cycle that follows, so back-to-back accesses are 3 cycles apart minimum.
- Latency: request cycle 0; bus_req in cycle 1; with ready in cycle 1, DONE/load_valid in cycle 2. mem_stall is high for cycles 0–1.
- Counter width: $clog2(TIMEOUT_CYCLES+1). The counter is cleared on entry to BUSY.

Test Plan:
- LW, ALU_Out=0x100, bus_rdata=0xDEADBEEF, ready in first BUSY cycle -> bus_addr=0x100, be=1111, we=0; load_valid=1 with load_data=0xDEADBEEF two cycles after request; mem_stall high exactly 2 cycles.
- SB, ALU_Out=0x203, rd2=0x000000A5 -> bus_addr=0x200, be=1000, bus_wdata=0xA5A5A5A5, we=1; no load_valid.
- LB at addr 0x101 with rdata 0x0000_8000, then LBU at the same address -> load_data=0xFFFFFF80, then 0x00000080.
- LH at 0x103, and LW at 0x102 -> no bus_req, mem_stall never high, access_fault pulses 1 cycle each.
- LW with bus_ready held 0, TIMEOUT_CYCLES=16 -> bus_req high 16 cycles then drops; access_fault=1, load_valid=0, load_data=0.
- n_rst asserted in the 3rd BUSY cycle -> bus_req=0 and mem_stall=0 at the next edge; a subsequent SW completes normally; MemRead+MemWr together with funct3=010 produces a write.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns execute-stage load/store requests into single
// req/ready bus transactions, with lane alignment, load extension and fault pulses.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        MemRead,
    input  logic        MemWr,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALU_Out,
    input  logic [31:0] rd2,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_fault
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_timeout;
    logic [2:0]      r_f3;
    logic [1:0]      r_lane;
    logic            w_req;
    logic            w_legal;
    logic            w_misal;
    logic            w_ok;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [31:0]     w_shifted;
    logic [31:0]     w_ext;

    // Write wins when both strobes are up, so legality is judged as a store.
    assign w_req = MemRead | MemWr;

    always_comb begin
        w_legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = ~MemWr;
            default:                w_legal = 1'b0;
        endcase
    end

    assign w_misal = ((funct3[1:0] == 2'b01) && ALU_Out[0]) ||
                     ((funct3[1:0] == 2'b10) && (ALU_Out[1:0] != 2'b00));
    assign w_ok    = w_legal & ~w_misal;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = rd2;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ALU_Out[1:0];
                w_wdata = {4{rd2[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << ALU_Out[1:0];
                w_wdata = {2{rd2[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = rd2;
            end
        endcase
    end

    assign w_shifted = bus_rdata >> {r_lane, 3'b000};

    always_comb begin
        w_ext = bus_rdata;
        case (r_f3)
            3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_ext = {24'd0, w_shifted[7:0]};
            3'b101:  w_ext = {16'd0, w_shifted[15:0]};
            default: w_ext = bus_rdata;
        endcase
    end

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_timeout = (w_cnt_inc == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        mem_stall    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req && w_ok) begin
                    w_state_next = BUSY;
                    mem_stall    = 1'b1;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (bus_ready || w_timeout) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        // Stall is combinational, so mask it while reset holds the pipeline anyway.
        if (n_rst) begin
            mem_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'd0;
            bus_wdata    <= 32'd0;
            bus_be       <= 4'd0;
            load_data    <= 32'd0;
            load_valid   <= 1'b0;
            access_fault <= 1'b0;
            r_cnt        <= '0;
            r_f3         <= 3'd0;
            r_lane       <= 2'd0;
        end else begin
            load_valid   <= 1'b0;
            access_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req && w_ok) begin
                        bus_req   <= 1'b1;
                        bus_we    <= MemWr;
                        bus_addr  <= {ALU_Out[31:2], 2'b00};
                        bus_be    <= w_be;
                        bus_wdata <= w_wdata;
                        r_f3      <= funct3;
                        r_lane    <= ALU_Out[1:0];
                        r_cnt     <= '0;
                    end else if (w_req) begin
                        access_fault <= 1'b1;
                    end
                end
                BUSY: begin
                    r_cnt <= w_cnt_inc;
                    if (bus_ready) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            load_data  <= w_ext;
                            load_valid <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        bus_req      <= 1'b0;
                        access_fault <= 1'b1;
                        load_data    <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
